mod_entrada_hex_32bit: RTL

//  Operator-entry front end of the calculator: builds the 32-bit hex number that the 7-segment

---
 rtl/mod_entrada_hex_32bit_pkg.sv | 14 +
 rtl/mod_entrada_hex_32bit_antirrebote.sv | 51 +++++
 rtl/mod_entrada_hex_32bit.sv | 100 ++++++++++
 3 files changed

// File: rtl/mod_entrada_hex_32bit_pkg.sv
// Shared types and sizes for the calculator operand-entry front end.
package pkg_calculadora;

    typedef enum logic [1:0] {
        VACIO      = 2'd0,
        EDITANDO   = 2'd1,
        CONFIRMADO = 2'd2
    } estado_entrada_t;

    localparam int NUM_DIGITOS  = 8;
    localparam int ANCHO_DIGITO = 4;
    localparam int ANCHO_VALOR  = NUM_DIGITOS * ANCHO_DIGITO;

endpackage

// File: rtl/mod_entrada_hex_32bit_antirrebote.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, and a
// single-cycle pulse on each debounced press (rising level only).
module mod_antirrebote #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_boton,
    output logic o_pulso
);

    localparam int ANCHO_CNT = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [ANCHO_CNT-1:0] CNT_MAX = ANCHO_CNT'(DEBOUNCE_CYCLES - 1);

    logic                 r_sync0;
    logic                 r_sync1;
    logic                 r_estable;
    logic                 r_pulso;
    logic [ANCHO_CNT-1:0] r_cnt;
    logic                 w_difiere;
    logic                 w_cambia;

    assign w_difiere = (r_sync1 != r_estable);
    // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    assign w_cambia  = w_difiere && (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync0   <= 1'b0;
            r_sync1   <= 1'b0;
            r_estable <= 1'b0;
            r_pulso   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync0 <= i_boton;
            r_sync1 <= r_sync0;
            r_pulso <= w_cambia && r_sync1;
            if (!w_difiere || w_cambia) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_cambia) begin
                r_estable <= r_sync1;
            end
        end
    end

    assign o_pulso = r_pulso;

endmodule

// File: rtl/mod_entrada_hex_32bit.sv
// Operator hex entry: debounced buttons drive a digit shift register with
// backspace, clear and confirm; a confirmed operand is handed on with a pulse.
module mod_entrada_hex_32bit
    import pkg_calculadora::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  sw_digito,
    input  logic        btn_ingresar,
    input  logic        btn_borrar,
    input  logic        btn_limpiar,
    input  logic        btn_confirmar,
    output logic [31:0] numero_entrada,
    output logic        pantalla_on,
    output logic [31:0] numero_listo,
    output logic        numero_valido,
    output logic [3:0]  cant_digitos,
    output logic        lleno
);

    localparam logic [3:0] CANT_MAX = 4'(NUM_DIGITOS);

    logic w_ingresar;
    logic w_borrar;
    logic w_limpiar;
    logic w_confirmar;

    estado_entrada_t        r_estado;
    logic [ANCHO_VALOR-1:0] r_valor;
    logic [ANCHO_VALOR-1:0] r_listo;
    logic                   r_valido;
    logic [3:0]             r_cant;

    mod_antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_ingresar (
        .clk(clk), .reset(reset), .i_boton(btn_ingresar), .o_pulso(w_ingresar)
    );
    mod_antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_borrar (
        .clk(clk), .reset(reset), .i_boton(btn_borrar), .o_pulso(w_borrar)
    );
    mod_antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_limpiar (
        .clk(clk), .reset(reset), .i_boton(btn_limpiar), .o_pulso(w_limpiar)
    );
    mod_antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_confirmar (
        .clk(clk), .reset(reset), .i_boton(btn_confirmar), .o_pulso(w_confirmar)
    );

    // Same-cycle pulses resolve as limpiar > confirmar > borrar > ingresar.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= VACIO;
            r_valor  <= '0;
            r_listo  <= '0;
            r_valido <= 1'b0;
            r_cant   <= '0;
        end else begin
            r_valido <= 1'b0;
            if (w_limpiar) begin
                r_valor  <= '0;
                r_cant   <= '0;
                r_estado <= VACIO;
            end else if (w_confirmar) begin
                if (r_estado != VACIO) begin
                    r_listo  <= r_valor;
                    r_valido <= 1'b1;
                    r_estado <= CONFIRMADO;
                end
            end else if (w_borrar) begin
                if (r_estado != VACIO) begin
                    r_valor  <= r_valor >> ANCHO_DIGITO;
                    r_cant   <= r_cant - 1'b1;
                    r_estado <= (r_cant == 4'd1) ? VACIO : EDITANDO;
                end
            end else if (w_ingresar) begin
                case (r_estado)
                    EDITANDO: begin
                        if (r_cant < CANT_MAX) begin
                            r_valor <= {r_valor[ANCHO_VALOR-ANCHO_DIGITO-1:0], sw_digito};
                            r_cant  <= r_cant + 1'b1;
                        end
                    end
                    default: begin
                        r_valor  <= {{(ANCHO_VALOR-ANCHO_DIGITO){1'b0}}, sw_digito};
                        r_cant   <= 4'd1;
                        r_estado <= EDITANDO;
                    end
                endcase
            end
        end
    end

    assign numero_entrada = r_valor;
    assign numero_listo   = r_listo;
    assign numero_valido  = r_valido;
    assign cant_digitos   = r_cant;
    assign pantalla_on    = (r_estado != VACIO);
    assign lleno          = (r_cant == CANT_MAX);

endmodule
